xor2_bist_exerciser: RTL and testbench

//   Synthesizable stimulus/response engine for a 2-input XOR gate (e.g. the NAND-built xor2).

---
 rtl/xor2_bist_exerciser.sv | 113 +++++++++++
 tb/tb_xor2_bist_exerciser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor2_bist_exerciser.sv
// xor2_bist_exerciser: on-chip stimulus/response engine for a 2-input XOR gate.
// Walks {a,b} through 00,01,10,11 for LOOPS passes. Each vector is held for
// SETTLE_CYCLES+1 cycles. On the last cycle of each hold the gate output is
// compared against a^b. Mismatches update a saturating error count and sticky
// per-vector fail flags.
module xor2_bist_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int SET_W  = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int LOOP_W = (LOOPS < 2) ? 1 : $clog2(LOOPS);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [SET_W-1:0]  settle_cnt;
  logic [LOOP_W-1:0] loop_cnt;
  logic [1:0]        vec;
  logic              sample;
  logic              mismatch;
  logic [ERR_W-1:0]  err_next;
  logic [3:0]        fail_next;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

  // The gate inputs come straight from the registered vector counter.
  // vec is forced to 00 outside a run, so a_o/b_o idle low.
  assign a_o = vec[1];
  assign b_o = vec[0];

  // Compare on the last settle cycle and form the next error state.
  always_comb begin
    sample    = (state == RUN) && (settle_cnt == SETTLE_LAST);
    mismatch  = sample && (y_i != (vec[1] ^ vec[0]));
    err_next  = mismatch ? sat_inc(err_count) : err_count;
    fail_next = fail_vec;
    if (mismatch) fail_next[vec] = 1'b1;
  end

  // Run-control FSM. It also holds the vector/settle/loop counters and the registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      loop_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            vec        <= '0;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
          end
        end
        RUN: begin
          err_count <= err_next;
          fail_vec  <= fail_next;
          if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end else begin
            settle_cnt <= '0;
            // 11 wraps to 00. This starts the next loop, or parks the inputs low in DONE.
            vec        <= vec + 2'd1;
            if (vec == 2'b11) begin
              if (loop_cnt == LOOP_LAST) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_next == '0);
              end else begin
                loop_cnt <= loop_cnt + LOOP_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor2_bist_exerciser.sv
// Scoreboard bench for xor2_bist_exerciser. The gate under test is modelled as a
// 4-entry truth table indexed by {a,b}. Each run pushes a reference result derived
// from that table. A negedge monitor pops and compares whenever done rises.
module tb_xor2_bist_exerciser;

  localparam int S       = 2;
  localparam int L       = 2;
  localparam int E       = 3;
  localparam int RUN_LEN = 4 * L * (S + 1);

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         a_o, b_o, y_i, busy, done, pass;
  logic [E-1:0] err_count;
  logic [3:0]   fail_vec;
  logic [3:0]   tt    = 4'b0110;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] err;
    logic [3:0] fv;
    logic       pass;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign y_i = tt[{a_o, b_o}];

  xor2_bist_exerciser #(
    .SETTLE_CYCLES(S),
    .LOOPS        (L),
    .ERR_W        (E)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_o      (a_o),
    .b_o      (b_o),
    .y_i      (y_i),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_vec (fail_vec)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: every vector is visited L times; a truth-table entry differing from XOR
  // is one mismatch per visit. The count clamps at 2**E-1.
  function automatic exp_t model(input logic [3:0] t);
    exp_t e;
    int   mism;
    mism = 0;
    e    = '0;
    for (int lp = 0; lp < L; lp++)
      for (int v = 0; v < 4; v++)
        if (int'(t[v]) != ((v >> 1) ^ (v & 1))) begin
          mism++;
          e.fv[v] = 1'b1;
        end
    e.err  = 8'((mism > (1 << E) - 1) ? (1 << E) - 1 : mism);
    e.pass = (mism == 0);
    return e;
  endfunction

  // Monitor: follows the a/b sequence while busy and scores each completed run.
  int   run_cyc = 0;
  int   seq_ok  = 1;
  logic done_q  = 1'b0;
  exp_t got_e;

  always @(negedge clk) begin
    if (rst) begin
      run_cyc = 0;
      seq_ok  = 1;
      done_q  = 1'b0;
    end else begin
      check("busy_done_exclusive", int'(busy && done), 0);
      if (busy) begin
        if ({a_o, b_o} != 2'((run_cyc / (S + 1)) % 4)) seq_ok = 0;
        run_cyc++;
      end else begin
        check("idle_ab_low", int'({a_o, b_o}), 0);
      end
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("busy_cycles", run_cyc, RUN_LEN);
          check("ab_sequence", seq_ok, 1);
          check("err_count", int'(err_count), int'(got_e.err));
          check("fail_vec", int'(fail_vec), int'(got_e.fv));
          check("pass", int'(pass), int'(got_e.pass));
        end
        run_cyc = 0;
        seq_ok  = 1;
      end
      done_q = done;
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < RUN_LEN * 4) begin
      @(posedge clk); #1;
      i++;
    end
    check("done_timeout", int'(done), 1);
  endtask

  task automatic run_tt(input logic [3:0] t);
    tt = t;
    exp_q.push_back(model(t));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("err_cleared_at_start", int'(err_count), 0);
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   i;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_fail_vec", int'(fail_vec), 0);
    check("rst_ab", int'({a_o, b_o}), 0);
    rst = 1'b0;

    // Fixed gates: correct XOR, stuck-at-0, OR, XNOR (saturates).
    run_tt(4'b0110);
    run_tt(4'b0000);
    run_tt(4'b1110);
    run_tt(4'b1001);

    // The results persist while parked in DONE.
    repeat (3) @(posedge clk);
    #1;
    e = model(4'b1001);
    check("hold_err", int'(err_count), int'(e.err));
    check("hold_fail_vec", int'(fail_vec), int'(e.fv));
    check("hold_done", int'(done), 1);

    // Abort a stuck-at-0 run during vector 10.
    tt = 4'b0000;
    exp_q.push_back(model(tt));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while (!(a_o && !b_o) && i < RUN_LEN * 2) begin
      @(posedge clk); #1;
      i++;
    end
    check("reach_vec10", int'({a_o, b_o}), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err", int'(err_count), 0);
    check("abort_fail_vec", int'(fail_vec), 0);
    check("abort_ab", int'({a_o, b_o}), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_stays_idle", int'(busy), 0);
    run_tt(4'b0110);

    // Hold start high through a stuck-at-0 run. The restart must wait for DONE.
    tt = 4'b0000;
    exp_q.push_back(model(tt));
    start = 1'b1;
    @(posedge clk); #1;
    wait_done();
    e = model(4'b0000);
    check("held_first_fail_vec", int'(fail_vec), int'(e.fv));
    tt = 4'b0110;
    exp_q.push_back(model(tt));
    @(posedge clk); #1;
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_done", int'(done), 0);
    check("held_restart_err", int'(err_count), 0);
    check("held_restart_fail_vec", int'(fail_vec), 0);
    start = 1'b0;
    wait_done();
    @(posedge clk); #1;

    // Randomised gate truth tables with random idle gaps.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_tt(4'($urandom_range(0, 15)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
